hex_keypad_emulator: RTL

//  Behavioural-synthesizable model of the 4x4 Grayhill 072 keypad as seen from the scanner side.
//  It accepts "press key N" requests and drives Row in response to the scanner's Col.

---
 rtl/hex_keypad_pkg.sv | 44 ++++
 rtl/hex_keypad_emulator_if.sv | 35 +++
 rtl/hex_keypad_row_drive.sv | 25 ++
 rtl/hex_keypad_emulator.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/hex_keypad_pkg.sv
// Shared definitions for the hex keypad emulator and the scanner that talks to it.
package hex_keypad_pkg;

  // Matrix geometry of the 4x4 keypad.
  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Press sequencing states of the emulator.
  typedef enum logic [2:0] {
    KP_IDLE    = 3'd0,
    KP_BNC_IN  = 3'd1,
    KP_HOLD    = 3'd2,
    KP_BNC_OUT = 3'd3,
    KP_GAP     = 3'd4
  } kp_state_e;

  // Column drive values used by the scanner: one column at a time, or all at once.
  localparam logic [COLS-1:0] COL_SCAN_0 = 4'b0001;
  localparam logic [COLS-1:0] COL_SCAN_1 = 4'b0010;
  localparam logic [COLS-1:0] COL_SCAN_2 = 4'b0100;
  localparam logic [COLS-1:0] COL_SCAN_3 = 4'b1000;
  localparam logic [COLS-1:0] COL_ALL    = 4'b1111;
  localparam logic [COLS-1:0] COL_NONE   = 4'b0000;

  // Row index of a key code (upper two bits).
  function automatic logic [1:0] code_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  // Column index of a key code (lower two bits).
  function automatic logic [1:0] code_col(input logic [3:0] code);
    return code[1:0];
  endfunction

  // Largest of three timing parameters; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/hex_keypad_emulator_if.sv
// Request/acknowledge handshake plus the Col/Row matrix lines between a
// requester/scanner (master) and the keypad emulator (slave).
interface hex_keypad_emulator_if;

  logic       key_req;
  logic [3:0] key_code;
  logic       key_ack;
  logic       busy;
  logic       done;
  logic [3:0] Col;
  logic [3:0] Row;

  // Requester and scanner side.
  modport master (
    output key_req,
    output key_code,
    output Col,
    input  key_ack,
    input  busy,
    input  done,
    input  Row
  );

  // Emulated keypad side.
  modport slave (
    input  key_req,
    input  key_code,
    input  Col,
    output key_ack,
    output busy,
    output done,
    output Row
  );

endinterface

// File: rtl/hex_keypad_row_drive.sv
// Combinational contact matrix: with the latched key closed, the row of that
// key follows the column line of that key. Purely combinational because the
// scanner samples Row in the same cycle it drives Col.
module hex_keypad_row_drive
  import hex_keypad_pkg::*;
(
  input  logic            contact,
  input  logic [3:0]      code,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row
);

  logic       col_hit;
  logic [1:0] key_row;

  // The key's column is being driven by the scanner.
  assign col_hit = col[code_col(code)];
  assign key_row = code_row(code);

  // Only the key's own row can ever be pulled, so row is zero or one-hot.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row[gi] = contact && (key_row == 2'(gi)) && col_hit;
  end

endmodule

// File: rtl/hex_keypad_emulator.sv
// Keypad stand-in for scanner verification: accepts one press request at a
// time and plays it out as bounce-in, solid hold, bounce-out and release gap.
module hex_keypad_emulator
  import hex_keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hex_keypad_emulator_if.slave kp
);

  localparam int MAX_CYCLES = max3(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Reload values; each phase counts down to zero in its last cycle.
  localparam logic [CNT_W-1:0] BNC_LOAD  = (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             contact_q, contact_d;
  logic [3:0]       code_q, code_d;

  logic             key_ack;
  logic             done;
  logic             busy;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter, contact and code computation; handshake decodes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    contact_d = contact_q;
    code_d    = code_q;
    key_ack   = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      KP_IDLE: begin
        contact_d = 1'b0;
        if (kp.key_req) begin
          key_ack   = 1'b1;
          code_d    = kp.key_code;
          // Contact closes in the cycle right after the accept, whether
          // or not the make is bouncy.
          contact_d = 1'b1;
          if (BOUNCE_CYCLES > 0) begin
            state_d = KP_BNC_IN;
            cnt_d   = BNC_LOAD;
          end else begin
            state_d = KP_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end

      KP_BNC_IN: begin
        if (cnt_zero) begin
          state_d   = KP_HOLD;
          cnt_d     = HOLD_LOAD;
          contact_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          contact_d = ~contact_q;
        end
      end

      KP_HOLD: begin
        contact_d = 1'b1;
        if (cnt_zero) begin
          // Break starts open, either as the first chatter cycle or the gap.
          contact_d = 1'b0;
          if (BOUNCE_CYCLES > 0) begin
            state_d = KP_BNC_OUT;
            cnt_d   = BNC_LOAD;
          end else begin
            state_d = KP_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      KP_BNC_OUT: begin
        if (cnt_zero) begin
          state_d   = KP_GAP;
          cnt_d     = GAP_LOAD;
          contact_d = 1'b0;
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          contact_d = ~contact_q;
        end
      end

      KP_GAP: begin
        contact_d = 1'b0;
        if (cnt_zero) begin
          done    = 1'b1;
          state_d = KP_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d   = KP_IDLE;
        cnt_d     = '0;
        contact_d = 1'b0;
      end
    endcase
  end

  // Busy covers every cycle of a press after the accept.
  always_comb begin
    busy = (state_q != KP_IDLE);
  end

  // State register; reset drops the contact immediately, even mid-press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= KP_IDLE;
      cnt_q     <= '0;
      contact_q <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
      code_q    <= code_d;
    end
  end

  assign kp.key_ack = key_ack;
  assign kp.busy    = busy;
  assign kp.done    = done;

  hex_keypad_row_drive u_row_drive (
    .contact (contact_q),
    .code    (code_q),
    .col     (kp.Col),
    .row     (kp.Row)
  );

endmodule
